cpu6_csr_file: RTL and testbench
================================

Name: cpu6_csr_file

Overview:
- Parametrised machine-mode CSR file for the cpu6 core; successor to the single-register mepc CSR block.
- Holds mstatus, mtvec, mepc, mcause, mscratch, mcycle and minstret, plus read-only mhartid.
- Supports read-modify-write CSR ops (write/set/clear), trap entry, mret, and 64-bit free-running counters.
- Sits beside the execute stage. It supplies the trap vector and return PC to the fetch redirect logic.

Parameters:
- XLEN, 32, datapath width (32 only; counter high halves exist because XLEN=32).
- MTVEC_RST, 32'h0000_0000, mtvec reset value (bits [1:0] must be 0).
- HART_ID, 0, value returned by mhartid (0xF14).
- CNT_EN, 1, 1 = mcycle/minstret implemented; 0 = both read 0, writes ignored, still legal.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- csr_rd_en  in  1  CSR read request
- csr_wr_en  in  1  CSR write request
- csr_op  in  2  00 write, 01 set (old|dat), 10 clear (old&~dat), 11 reserved (treated as no write)
- csr_idx  in  12  CSR address
- csr_write_dat  in  XLEN  write/set/clear operand
- csr_read_dat  out  XLEN  combinational read data of selected CSR (pre-update value)
- csr_illegal  out  1  combinational: access to an unimplemented CSR, or write to a read-only CSR
- excp_ena  in  1  trap entry this cycle
- excp_mepc  in  XLEN  PC of trapping instruction
- excp_mcause  in  XLEN  cause code
- mret_ena  in  1  mret retires this cycle
- instret_inc  in  1  one instruction retired this cycle
- trap_vec  out  XLEN  {mtvec[XLEN-1:2],2'b00}
- mret_pc  out  XLEN  current mepc
- mie  out  1  mstatus.MIE

Behaviour:
- One clock, clk. reset is synchronous, active-high and sampled on the rising edge. Reset takes priority over all other inputs, including in the same cycle as any request.
- Reset values:
  - mstatus = 0 (MIE bit3 = 0, MPIE bit7 = 0, all other bits hardwired 0).
  - mtvec = MTVEC_RST.
  - mepc, mcause, mscratch = 0.
  - mcycle, minstret = 64'h0.
  - Outputs follow the registers, so after reset trap_vec = MTVEC_RST, mret_pc = 0, mie = 0.
- Address map:
  - 0x300 mstatus; 0x305 mtvec; 0x340 mscratch; 0x341 mepc; 0x342 mcause.
  - 0xB00/0xB80 mcycle lo/hi; 0xB02/0xB82 minstret lo/hi.
  - 0xF14 mhartid (RO).
  - Any other index: read 0, csr_illegal = 1 when rd_en or wr_en is set.
- Read path is combinational. csr_read_dat = 0 when csr_rd_en = 0. It always returns the register value before this cycle's update.
- Write value: nxt = op-combine(old, csr_write_dat). The result is committed on the next rising edge, only when csr_wr_en = 1 and csr_illegal = 0.
- Write masks:
  - mepc bit0 is forced 0.
  - mtvec bits[1:0] are forced 0 (direct mode only).
  - mstatus: only bits 3 and 7 are writable.
- Write to mhartid: csr_illegal = 1 and no state change. Read of mhartid returns HART_ID.
- Trap entry (excp_ena = 1), all in one edge:
  - mepc <= {excp_mepc[XLEN-1:1],0}.
  - mcause <= excp_mcause.
  - MPIE <= MIE.
  - MIE <= 0.
- mret (mret_ena = 1), one edge: MIE <= MPIE, MPIE <= 1.
- Priority per register:
  - reset > excp_ena > mret_ena > CSR write.
  - A CSR write to mepc, mcause or mstatus in a trap cycle is dropped.
  - excp_ena together with mret_ena: trap wins, mret is ignored.
- Counters:
  - mcycle increments by 1 every non-reset cycle.
  - minstret increments when instret_inc = 1.
  - Both wrap 64'hFFFF_FFFF_FFFF_FFFF -> 0.
  - A CSR write to either half replaces that half and suppresses the increment of the whole 64-bit counter in that cycle; the other half holds.
  - Carry from lo into hi is computed on the pre-write value only when there is no write.
- Latency: all state updates are visible on csr_read_dat, trap_vec, mret_pc and mie in the cycle after the edge.

Test Plan:
- Reset held 2 cycles, then read all CSRs -> mstatus 0, mtvec MTVEC_RST, mepc/mcause/mscratch 0, mhartid HART_ID; mcycle lo reads 1 on the first cycle after reset release.
- Write mtvec 0x8000_0107, then set 0x0000_0010, then clear 0x0000_0100 -> reads 0x8000_0104, 0x8000_0114, 0x8000_0014; trap_vec tracks each value.
- Set MIE (set 0x8 on 0x300); trap with excp_mepc 0x1235, mcause 0xB in the same cycle as a CSR write to mepc of 0x5555 -> mepc 0x1234, mcause 0xB, MIE 0, MPIE 1; the mepc write is lost. Then mret -> MIE 1, MPIE 1.
- Write mcycle lo 0xFFFF_FFFF with hi 0 and let it run -> hi reads 1, lo reads 0 one cycle later; write hi 0xFFFF_FFFF with lo 0xFFFF_FFFF -> wraps to 0.
- instret_inc pulsed 5 times with gaps -> minstret = 5; mcycle counts every cycle.
- Access 0x7C0 with rd_en -> csr_illegal 1, data 0. Write 0xF14 -> illegal 1, no change. Assert reset mid trap -> all values return to reset.

Source files
------------

// File: rtl/cpu6_csr_file.sv
// rtl/cpu6_csr_file.sv - machine-mode CSR file for the cpu6 core
//
// Purpose: holds mstatus (MIE/MPIE), mtvec, mepc, mcause, mscratch, the
// 64-bit mcycle/minstret counters and read-only mhartid. It executes CSR
// write/set/clear ops, trap entry and mret, and supplies the trap vector
// and return PC to the fetch redirect logic.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   csr_rd_en, csr_wr_en        CSR access strobes
//   csr_op                      00 write, 01 set, 10 clear, 11 no write
//   csr_idx, csr_write_dat      CSR address and operand
//   csr_read_dat                combinational pre-update read data
//   csr_illegal                 unimplemented CSR or write to read-only CSR
//   excp_ena/mepc/mcause        trap entry request and its PC and cause
//   mret_ena                    mret retires this cycle
//   instret_inc                 one instruction retired this cycle
//   trap_vec, mret_pc, mie      redirect targets and mstatus.MIE
module cpu6_csr_file #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter logic [XLEN-1:0] HART_ID   = '0,
  parameter bit              CNT_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            csr_rd_en,
  input  logic            csr_wr_en,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_idx,
  input  logic [XLEN-1:0] csr_write_dat,
  output logic [XLEN-1:0] csr_read_dat,
  output logic            csr_illegal,
  input  logic            excp_ena,
  input  logic [XLEN-1:0] excp_mepc,
  input  logic [XLEN-1:0] excp_mcause,
  input  logic            mret_ena,
  input  logic            instret_inc,
  output logic [XLEN-1:0] trap_vec,
  output logic [XLEN-1:0] mret_pc,
  output logic            mie
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MCYC_LO  = 12'hB00;
  localparam logic [11:0] A_MCYC_HI  = 12'hB80;
  localparam logic [11:0] A_MINS_LO  = 12'hB02;
  localparam logic [11:0] A_MINS_HI  = 12'hB82;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] MEPC_MASK  = {{(XLEN-1){1'b1}}, 1'b0};
  localparam logic [XLEN-1:0] MTVEC_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic              mie_q, mie_d;
  logic              mpie_q, mpie_d;
  logic [XLEN-1:0]   mtvec_q, mtvec_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;
  logic [XLEN-1:0]   mcause_q, mcause_d;
  logic [XLEN-1:0]   mscratch_q, mscratch_d;
  logic [2*XLEN-1:0] mcycle_q, mcycle_d;
  logic [2*XLEN-1:0] minstret_q, minstret_d;

  logic              sel_mstatus, sel_mtvec, sel_mscratch, sel_mepc, sel_mcause;
  logic              sel_mcyc_lo, sel_mcyc_hi, sel_mins_lo, sel_mins_hi, sel_mhartid;
  logic              implemented;
  logic [XLEN-1:0]   mstatus_val;
  logic [XLEN-1:0]   rdata_raw;
  logic [XLEN-1:0]   nxt;
  logic              wr_commit;

  // Address decode, read mux and op-combine.
  always_comb begin
    sel_mstatus  = (csr_idx == A_MSTATUS);
    sel_mtvec    = (csr_idx == A_MTVEC);
    sel_mscratch = (csr_idx == A_MSCRATCH);
    sel_mepc     = (csr_idx == A_MEPC);
    sel_mcause   = (csr_idx == A_MCAUSE);
    sel_mcyc_lo  = (csr_idx == A_MCYC_LO);
    sel_mcyc_hi  = (csr_idx == A_MCYC_HI);
    sel_mins_lo  = (csr_idx == A_MINS_LO);
    sel_mins_hi  = (csr_idx == A_MINS_HI);
    sel_mhartid  = (csr_idx == A_MHARTID);
    implemented  = sel_mstatus | sel_mtvec | sel_mscratch | sel_mepc | sel_mcause |
                   sel_mcyc_lo | sel_mcyc_hi | sel_mins_lo | sel_mins_hi | sel_mhartid;

    mstatus_val    = '0;
    mstatus_val[3] = mie_q;
    mstatus_val[7] = mpie_q;

    rdata_raw = '0;
    unique case (1'b1)
      sel_mstatus:  rdata_raw = mstatus_val;
      sel_mtvec:    rdata_raw = mtvec_q;
      sel_mscratch: rdata_raw = mscratch_q;
      sel_mepc:     rdata_raw = mepc_q;
      sel_mcause:   rdata_raw = mcause_q;
      sel_mcyc_lo:  rdata_raw = CNT_EN ? mcycle_q[XLEN-1:0]        : '0;
      sel_mcyc_hi:  rdata_raw = CNT_EN ? mcycle_q[2*XLEN-1:XLEN]   : '0;
      sel_mins_lo:  rdata_raw = CNT_EN ? minstret_q[XLEN-1:0]      : '0;
      sel_mins_hi:  rdata_raw = CNT_EN ? minstret_q[2*XLEN-1:XLEN] : '0;
      sel_mhartid:  rdata_raw = HART_ID;
      default:      rdata_raw = '0;
    endcase

    csr_illegal  = ((csr_rd_en | csr_wr_en) & ~implemented) | (csr_wr_en & sel_mhartid);
    csr_read_dat = csr_rd_en ? rdata_raw : '0;

    unique case (csr_op)
      2'b00:   nxt = csr_write_dat;
      2'b01:   nxt = rdata_raw | csr_write_dat;
      2'b10:   nxt = rdata_raw & ~csr_write_dat;
      default: nxt = rdata_raw;
    endcase

    // The reserved op still decodes as an access but never commits.
    wr_commit = csr_wr_en & ~csr_illegal & (csr_op != 2'b11);
  end

  // Next-state: trap beats mret, which beats a CSR write.
  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mscratch_d = mscratch_q;
    mcycle_d   = mcycle_q;
    minstret_d = minstret_q;

    if (excp_ena) begin
      mpie_d = mie_q;
      mie_d  = 1'b0;
    end else if (mret_ena) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (wr_commit && sel_mstatus) begin
      mie_d  = nxt[3];
      mpie_d = nxt[7];
    end

    if (excp_ena) begin
      mepc_d   = excp_mepc & MEPC_MASK;
      mcause_d = excp_mcause;
    end else begin
      if (wr_commit && sel_mepc)   mepc_d   = nxt & MEPC_MASK;
      if (wr_commit && sel_mcause) mcause_d = nxt;
    end

    if (wr_commit && sel_mtvec)    mtvec_d    = nxt & MTVEC_MASK;
    if (wr_commit && sel_mscratch) mscratch_d = nxt;

    // A write to either half freezes the whole counter for that cycle.
    if (CNT_EN) begin
      if (wr_commit && sel_mcyc_lo)      mcycle_d[XLEN-1:0]        = nxt;
      else if (wr_commit && sel_mcyc_hi) mcycle_d[2*XLEN-1:XLEN]   = nxt;
      else                               mcycle_d = mcycle_q + 1'b1;

      if (wr_commit && sel_mins_lo)      minstret_d[XLEN-1:0]      = nxt;
      else if (wr_commit && sel_mins_hi) minstret_d[2*XLEN-1:XLEN] = nxt;
      else if (instret_inc)              minstret_d = minstret_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= MTVEC_RST;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mscratch_q <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mscratch_q <= mscratch_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  assign trap_vec = mtvec_q & MTVEC_MASK;
  assign mret_pc  = mepc_q;
  assign mie      = mie_q;

endmodule

// File: tb/tb_cpu6_csr_file.sv
// tb/tb_cpu6_csr_file.sv - scoreboard testbench for cpu6_csr_file
module tb_cpu6_csr_file;

  localparam logic [31:0] MTVEC_RST = 32'h0000_1000;
  localparam logic [31:0] HART_ID   = 32'h0000_0003;

  localparam int K_RD   = 0;
  localparam int K_TVEC = 1;
  localparam int K_MPC  = 2;
  localparam int K_MIE  = 3;
  localparam int K_ILL  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        csr_rd_en = 1'b0;
  logic        csr_wr_en = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_idx = 12'h000;
  logic [31:0] csr_write_dat = 32'h0;
  logic [31:0] csr_read_dat;
  logic        csr_illegal;
  logic        excp_ena = 1'b0;
  logic [31:0] excp_mepc = 32'h0;
  logic [31:0] excp_mcause = 32'h0;
  logic        mret_ena = 1'b0;
  logic        instret_inc = 1'b0;
  logic [31:0] trap_vec;
  logic [31:0] mret_pc;
  logic        mie;

  cpu6_csr_file #(
    .XLEN(32), .MTVEC_RST(MTVEC_RST), .HART_ID(HART_ID), .CNT_EN(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .csr_rd_en(csr_rd_en), .csr_wr_en(csr_wr_en), .csr_op(csr_op),
    .csr_idx(csr_idx), .csr_write_dat(csr_write_dat),
    .csr_read_dat(csr_read_dat), .csr_illegal(csr_illegal),
    .excp_ena(excp_ena), .excp_mepc(excp_mepc), .excp_mcause(excp_mcause),
    .mret_ena(mret_ena), .instret_inc(instret_inc),
    .trap_vec(trap_vec), .mret_pc(mret_pc), .mie(mie)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            kind;
    logic [31:0]   exp;
    logic [8*12-1:0] name;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic push(input int k, input logic [31:0] e, input logic [8*12-1:0] nm);
    exp_t x;
    x.kind = k;
    x.exp  = e;
    x.name = nm;
    q.push_back(x);
  endtask

  // Advance one edge, then return all request inputs to idle.
  task automatic step();
    @(posedge clk);
    #1;
    csr_rd_en = 1'b0; csr_wr_en = 1'b0; csr_op = 2'b00; csr_idx = 12'h000;
    csr_write_dat = 32'h0; excp_ena = 1'b0; excp_mepc = 32'h0; excp_mcause = 32'h0;
    mret_ena = 1'b0; instret_inc = 1'b0;
  endtask

  task automatic rd(input logic [11:0] idx, input logic [31:0] e, input logic [8*12-1:0] nm);
    csr_rd_en = 1'b1;
    csr_idx   = idx;
    push(K_RD, e, nm);
  endtask

  task automatic wr(input logic [11:0] idx, input logic [1:0] op, input logic [31:0] d);
    csr_wr_en     = 1'b1;
    csr_idx       = idx;
    csr_op        = op;
    csr_write_dat = d;
  endtask

  // Monitor: DUT outputs are sampled mid-cycle and checked against the queue.
  initial begin
    logic [31:0] act;
    exp_t x;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        x = q.pop_front();
        case (x.kind)
          K_RD:    act = csr_read_dat;
          K_TVEC:  act = trap_vec;
          K_MPC:   act = mret_pc;
          K_MIE:   act = {31'b0, mie};
          default: act = {31'b0, csr_illegal};
        endcase
        n_chk++;
        if (act !== x.exp) begin
          n_fail++;
          $display("FAIL %0s: got %h expected %h at %0t", x.name, act, x.exp, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for two edges.
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    push(K_TVEC, MTVEC_RST, "rst_tvec");
    push(K_MPC,  32'h0,     "rst_mretpc");
    push(K_MIE,  32'h0,     "rst_mie");
    rd(12'h300, 32'h0, "rst_mstatus");
    push(K_ILL,  32'h0,     "rst_ill");
    step(); rd(12'hB00, 32'h1, "rst_mcyc1");
    step(); rd(12'h305, MTVEC_RST, "rst_mtvec");
    step(); rd(12'h341, 32'h0, "rst_mepc");
    step(); rd(12'h342, 32'h0, "rst_mcause");
    step(); rd(12'h340, 32'h0, "rst_mscratch");
    step(); rd(12'hF14, HART_ID, "rst_mhartid");
    step(); csr_idx = 12'h305; push(K_RD, 32'h0, "rd_gated");

    // mtvec write / set / clear, each read back pre-update next cycle.
    step(); wr(12'h305, 2'b00, 32'h8000_0107); push(K_TVEC, MTVEC_RST, "tvec_hold");
    step(); rd(12'h305, 32'h8000_0104, "mtvec_wr");  push(K_TVEC, 32'h8000_0104, "tvec_wr");
            wr(12'h305, 2'b01, 32'h0000_0010);
    step(); rd(12'h305, 32'h8000_0114, "mtvec_set"); push(K_TVEC, 32'h8000_0114, "tvec_set");
            wr(12'h305, 2'b10, 32'h0000_0100);
    step(); rd(12'h305, 32'h8000_0014, "mtvec_clr"); push(K_TVEC, 32'h8000_0014, "tvec_clr");

    // Trap entry beats a same-cycle mepc write; then mret.
    step(); wr(12'h300, 2'b01, 32'h8);
    step(); rd(12'h300, 32'h8, "mie_set"); push(K_MIE, 32'h1, "mie_out1");
    step(); wr(12'h341, 2'b00, 32'h5555);
            excp_ena = 1'b1; excp_mepc = 32'h1235; excp_mcause = 32'hB;
            push(K_ILL, 32'h0, "ill_mepc");
    step(); rd(12'h341, 32'h1234, "trap_mepc"); push(K_MPC, 32'h1234, "trap_mretpc");
            push(K_MIE, 32'h0, "trap_mie");
    step(); rd(12'h342, 32'hB, "trap_mcause");
    step(); rd(12'h300, 32'h80, "trap_mstat"); mret_ena = 1'b1;
    step(); rd(12'h300, 32'h88, "mret_mstat"); push(K_MIE, 32'h1, "mret_mie");
    step(); wr(12'h300, 2'b10, 32'hFFFF_FFF7);
    step(); rd(12'h300, 32'h08, "mstat_clr");
            wr(12'h300, 2'b00, 32'hFFFF_FFFF);
    step(); rd(12'h300, 32'h88, "mstat_mask");
    step(); wr(12'h341, 2'b00, 32'h2223);
    step(); rd(12'h341, 32'h2222, "mepc_bit0"); push(K_MPC, 32'h2222, "mretpc_wr");
    step(); wr(12'h340, 2'b00, 32'hDEAD_BEEF);
    step(); rd(12'h340, 32'hDEAD_BEEF, "mscratch");
            wr(12'h340, 2'b11, 32'h1234);
    step(); rd(12'h340, 32'hDEAD_BEEF, "op_rsvd");

    // mcycle carry lo->hi and full 64-bit wrap.
    step(); wr(12'hB00, 2'b00, 32'hFFFF_FFFF);
    step(); rd(12'hB00, 32'hFFFF_FFFF, "mcyc_lo_wr");
    step(); rd(12'hB00, 32'h0, "mcyc_lo_wrap");
    step(); rd(12'hB80, 32'h1, "mcyc_carry");
    step(); wr(12'hB00, 2'b00, 32'hFFFF_FFFF);
    step(); rd(12'hB80, 32'h1, "mcyc_hi_hold");
            wr(12'hB80, 2'b00, 32'hFFFF_FFFF);
    step(); rd(12'hB80, 32'hFFFF_FFFF, "mcyc_hi_wr");
    step(); rd(12'hB80, 32'h0, "mcyc_wrap_hi");
    step(); rd(12'hB00, 32'h1, "mcyc_wrap_lo");
    step(); wr(12'hB00, 2'b00, 32'h10);
    step(); rd(12'hB00, 32'h10, "mcyc_run0");
    step();
    step();
    step(); rd(12'hB00, 32'h13, "mcyc_run3");

    // minstret: five pulses with gaps, then write-vs-increment.
    for (int i = 0; i < 5; i++) begin
      step(); instret_inc = 1'b1;
      step();
    end
    step(); rd(12'hB02, 32'h5, "minst_5");
    step(); rd(12'hB82, 32'h0, "minst_hi");
    step(); wr(12'hB02, 2'b00, 32'd100); instret_inc = 1'b1;
    step(); rd(12'hB02, 32'd100, "minst_wrinc");

    // Illegal accesses.
    step(); rd(12'h7C0, 32'h0, "ill_rd_dat"); push(K_ILL, 32'h1, "ill_rd");
    step(); wr(12'h7C0, 2'b00, 32'h1); push(K_ILL, 32'h1, "ill_wr");
    step(); wr(12'hF14, 2'b00, 32'h55); push(K_ILL, 32'h1, "ill_hartwr");
    step(); rd(12'hF14, HART_ID, "hart_nochg"); push(K_ILL, 32'h0, "hart_rd_ok");

    // Reset asserted in a trap cycle wins over the trap.
    step(); excp_ena = 1'b1; excp_mepc = 32'h4444; excp_mcause = 32'h7; reset = 1'b1;
    step(); reset = 1'b0;
            rd(12'hB00, 32'h0, "mr_mcyc");
            push(K_TVEC, MTVEC_RST, "mr_tvec");
            push(K_MPC,  32'h0,     "mr_mretpc");
            push(K_MIE,  32'h0,     "mr_mie");
    step(); rd(12'h341, 32'h0, "mr_mepc");
    step(); rd(12'h342, 32'h0, "mr_mcause");
    step(); rd(12'h340, 32'h0, "mr_mscratch");
    step(); rd(12'h300, 32'h0, "mr_mstatus");
    step(); rd(12'h305, MTVEC_RST, "mr_mtvec");
    step(); rd(12'hB02, 32'h0, "mr_minst");
    step();
    step();

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
